atomic_mem_responder: RTL

- Data-side responder for the memory-stage request signals MemRead, MemWrite and datomic.
- Sits between the memory stage and the dcache. Services LW/SW directly and implements LL/SC semantics with a single-entry link register.
- Clears the reservation on coherence snoop invalidates, local stores, halt and (optionally) timeout.
- Returns the SC success flag (1/0) as load data, so the existing MemtoReg=01 writeback path deposits it in rt.

---
 rtl/atomic_mem_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/atomic_mem_responder.sv
// atomic_mem_responder: memory-stage data responder with LL/SC support.
// LW/SW go straight to the dcache. LL/SC use a single-entry link register.
// The reservation is cleared by coherence invalidates, local stores, halt,
// and, when RSV_TIMEOUT_EN is defined, by a lifetime down-counter.
// Optional feature macro: RSV_TIMEOUT_EN.
module atomic_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RSV_TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_halt,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dstore,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dload,
  input  logic              ccinv,
  input  logic [ADDR_W-1:0] ccsnoopaddr,
  output logic              link_valid
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, SCFAIL} state_t;

  state_t            state;
  logic              req_atomic;
  logic [ADDR_W-1:0] link_addr;
  logic              link_kill;
  logic              ll_kill;
  logic              ll_set;
  logic              sc_ok;
  logic              expire;

  // Word-granular compare; byte offset bits never matter for reservations.
  function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

  // Events that kill the current reservation this cycle.
  assign link_kill = (ccinv & word_match(ccsnoopaddr, link_addr)) | mem_halt | expire;
  // Events that prevent an LL completing this cycle from taking the link.
  assign ll_kill   = mem_halt | (ccinv & word_match(ccsnoopaddr, daddr));
  assign ll_set    = (state == READ) & dhit & req_atomic & ~ll_kill;
  // SC only proceeds to the dcache if the link is still good after this cycle.
  assign sc_ok     = link_valid & word_match(mem_addr, link_addr) & ~link_kill;

`ifdef RSV_TIMEOUT_EN
  localparam int CNT_W = $clog2(RSV_TIMEOUT + 1);
  logic [CNT_W-1:0] rsv_cnt;

  // Reservation lifetime counter: loaded by LL, counts down while linked.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsv_cnt <= '0;
    end else if (ll_set) begin
      rsv_cnt <= CNT_W'(RSV_TIMEOUT);
    end else if (link_valid && rsv_cnt != '0) begin
      rsv_cnt <= rsv_cnt - 1'b1;
    end
  end

  assign expire = link_valid & (rsv_cnt == CNT_W'(1));
`else
  assign expire = 1'b0;
`endif

  // Request FSM; dcache strobes, address and store data are registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      dREN       <= 1'b0;
      dWEN       <= 1'b0;
      daddr      <= '0;
      dstore     <= '0;
      req_atomic <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!mem_halt && (MemRead || MemWrite)) begin
            daddr      <= mem_addr;
            dstore     <= mem_wdata;
            req_atomic <= datomic;
            // Read+write together is illegal; the write takes precedence.
            if (MemWrite) begin
              if (!datomic || sc_ok) begin
                state <= WRITE;
                dWEN  <= 1'b1;
              end else begin
                state <= SCFAIL;
              end
            end else begin
              state <= READ;
              dREN  <= 1'b1;
            end
          end
        end
        READ: begin
          if (dhit) begin
            state <= IDLE;
            dREN  <= 1'b0;
          end
        end
        WRITE: begin
          if (dhit) begin
            state <= IDLE;
            dWEN  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Link register: clears on kill events, set by LL completion, dropped by stores/SC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      if (link_kill) link_valid <= 1'b0;
      case (state)
        READ: begin
          if (dhit && req_atomic) begin
            if (ll_kill) begin
              link_valid <= 1'b0;
            end else begin
              link_valid <= 1'b1;
              link_addr  <= daddr;
            end
          end
        end
        WRITE: begin
          if (dhit && (req_atomic || word_match(daddr, link_addr))) link_valid <= 1'b0;
        end
        SCFAIL: link_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Completion pulse coincides with dhit so load data is returned unbuffered.
  assign mem_done = (((state == READ) || (state == WRITE)) && dhit) || (state == SCFAIL);

  // Load data, or the SC success flag for the MemtoReg writeback path.
  always_comb begin
    mem_rdata = '0;
    if (state == READ && dhit)                     mem_rdata = dload;
    else if (state == WRITE && dhit && req_atomic) mem_rdata = {{(DATA_W-1){1'b0}}, 1'b1};
  end

endmodule
